// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// behind a start/done valid-ready handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic             br_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             borrow_out_reg;

  logic d_bit;
  logic br_next;

  // Full-subtractor cell applied to the current LSBs of the shift registers.
  assign d_bit   = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
  assign br_next = (~a_sh_reg[0] & (b_sh_reg[0] | br_reg)) | (b_sh_reg[0] & br_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      br_reg         <= 1'b0;
      cnt_reg        <= '0;
      result_reg     <= '0;
      borrow_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            a_sh_reg       <= a;
            b_sh_reg       <= b;
            br_reg         <= borrow_in;
            cnt_reg        <= '0;
            result_reg     <= '0;
            borrow_out_reg <= 1'b0;
            state_reg      <= RUN;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so bit i lands at position i after WIDTH shifts.
          result_reg <= {d_bit, result_reg[WIDTH-1:1]};
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          br_reg     <= br_next;
          if (cnt_reg == CNT_LAST) begin
            borrow_out_reg <= br_next;
            state_reg      <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (done_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_reg == IDLE);
  assign done_valid  = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign result      = result_reg;
  assign borrow_out  = borrow_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against a plain-arithmetic
// model of a - b - borrow_in over WIDTH+1 bits.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .result     (result),
    .borrow_out (borrow_out),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic bin);
    int unsigned diff;
    diff = (int'(x) - int'(y) - int'(bin)) & ((1 << (WIDTH + 1)) - 1);
    return diff[WIDTH:0];
  endfunction

  // One full transaction; called and returning on a falling edge.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic op_bin, input int hold, input bit verbose);
    logic [WIDTH:0] exp;
    int wait_cnt;
    int lat;
    exp = ref_sub(op_a, op_b, op_bin);
    wait_cnt = 0;
    while (!start_ready && wait_cnt < 20) begin
      @(posedge clk);
      @(negedge clk);
      wait_cnt++;
    end
    check("start_ready", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a           = op_a;
    b           = op_b;
    borrow_in   = op_bin;
    @(posedge clk);
    @(negedge clk);
    check("busy_run", 32'(busy), 32'd1);
    check("start_ready_run", 32'(start_ready), 32'd0);
    // Operand, start and done_ready noise during RUN must be ignored.
    lat = 0;
    while (!done_valid && lat < 20) begin
      start_valid = 1'($urandom);
      done_ready  = 1'($urandom);
      a           = WIDTH'($urandom);
      b           = WIDTH'($urandom);
      borrow_in   = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start_valid = 1'b0;
    done_ready  = 1'b0;
    check("latency", 32'(lat), 32'(WIDTH));
    check("result", 32'(result), 32'(exp[WIDTH-1:0]));
    check("borrow_out", 32'(borrow_out), 32'(exp[WIDTH]));
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      a           = 8'h11;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(done_valid), 32'd1);
      check("hold_result", 32'(result), 32'(exp[WIDTH-1:0]));
      check("hold_borrow", 32'(borrow_out), 32'(exp[WIDTH]));
      check("hold_busy", 32'(busy), 32'd1);
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_ready = 1'b0;
    check("done_drop", 32'(done_valid), 32'd0);
    check("idle_ready", 32'(start_ready), 32'd1);
    check("kept_result", 32'(result), 32'(exp[WIDTH-1:0]));
    check("kept_borrow", 32'(borrow_out), 32'(exp[WIDTH]));
    if (verbose)
      $display("op a=%02h b=%02h bin=%0d -> result=%02h borrow_out=%0d lat=%0d",
               op_a, op_b, op_bin, result, borrow_out, lat);
  endtask

  initial begin
    int seen_valid;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    a           = '0;
    b           = '0;
    borrow_in   = 1'b0;
    #1;
    check("rst_result", 32'(result), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_valid", 32'(done_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 0, 1'b1);
    run_op(8'h03, 8'h05, 1'b0, 1, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b1);
    run_op(8'h80, 8'h01, 1'b0, 5, 1'b1);

    // Reset abandons an operation in its 4th RUN cycle.
    start_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    borrow_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_borrow", 32'(borrow_out), 32'd0);
    check("mid_rst_valid", 32'(done_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_valid) seen_valid++;
    end
    check("no_valid_after_rst", 32'(seen_valid), 32'd0);
    $display("reset mid-run: done_valid pulses after release=%0d", seen_valid);
    run_op(8'h10, 8'h01, 1'b0, 0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; the module SHALL support WIDTH >= 2.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port start_valid, input, 1: a request is presented.
REQ-005 Port start_ready, output, 1: the block can accept a request.
REQ-006 Port a, input, WIDTH: minuend, sampled only at accept.
REQ-007 Port b, input, WIDTH: subtrahend, sampled only at accept.
REQ-008 Port borrow_in, input, 1: initial borrow into bit 0, sampled only at accept.
REQ-009 Port result, output, WIDTH: difference a - b - borrow_in, modulo 2^WIDTH.
REQ-010 Port borrow_out, output, 1: borrow out of bit WIDTH-1.
REQ-011 Port done_valid, output, 1: result and borrow_out are valid.
REQ-012 Port done_ready, input, 1: the consumer takes the result.
REQ-013 Port busy, output, 1: high in RUN and DONE.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, held in a registered state variable.
REQ-015 In IDLE, start_ready SHALL be 1; start_ready SHALL be 0 in RUN and DONE.
REQ-016 Accept occurs on a rising edge with start_valid=1 and start_ready=1.
  - a, b and borrow_in are loaded into internal shift and borrow registers.
  - The bit counter is cleared.
  - The result register is cleared.
  - The state goes to RUN.
REQ-017 In RUN, exactly one bit per cycle SHALL be processed, LSB first:
  - d = a0 ^ b0 ^ br;
  - br_next = (~a0 & (b0 | br)) | (b0 & br).
REQ-018 In RUN, each cycle:
  - d SHALL be shifted into result at the MSB while the register shifts right, so after WIDTH cycles bit i of result holds difference bit i.
  - The operand registers SHALL shift right by one.
REQ-019 The counter SHALL increment once per RUN cycle; on the edge that processes bit WIDTH-1, the state SHALL go to DONE and borrow_out SHALL take br_next.
REQ-020 Latency: with accept on edge k, done_valid SHALL rise after edge k+WIDTH and never earlier.
REQ-021 In DONE:
  - done_valid SHALL be 1.
  - result and borrow_out SHALL stay stable until the handshake.
REQ-022 A handshake occurs when done_valid=1 and done_ready=1 on a rising edge; the state SHALL return to IDLE.
  - done_valid SHALL drop after that edge.
  - result and borrow_out SHALL keep their values until the next accept.
REQ-023 A new accept SHALL NOT happen in the same cycle as the done handshake; the earliest next accept is the edge after the return to IDLE.
REQ-024 start_valid in RUN or DONE SHALL be ignored with no state change.
  - Changes on a, b or borrow_in after accept SHALL NOT affect the operation in progress.
REQ-025 done_ready while not in DONE SHALL be ignored.
REQ-026 done_valid SHALL stay high for as long as done_ready is held low (backpressure), with no limit on duration.
REQ-027 The counter SHALL be wide enough to hold WIDTH-1 and SHALL NOT wrap during RUN.

Reset
REQ-028 When rst_n=0, immediately and regardless of clk:
  - the state SHALL be IDLE;
  - result, borrow_out, done_valid and busy SHALL be 0, and start_ready SHALL be 1;
  - the shift registers, borrow register and counter SHALL be cleared.
REQ-029 Reset in RUN or DONE SHALL abandon the operation; no done_valid pulse SHALL follow the release.
REQ-030 An accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, borrow_in=0 -> result=0x02, borrow_out=0; done_valid rises exactly 8 cycles after accept.
REQ-032 a=0x03, b=0x05, borrow_in=0 -> result=0xFE, borrow_out=1.
REQ-033 a=0x00, b=0x00, borrow_in=1 -> result=0xFF, borrow_out=1.
REQ-034 Backpressure: a=0x80, b=0x01, borrow_in=0, with done_ready held 0 for 5 cycles after done_valid rises.
  - done_valid stays 1 with result=0x7F and borrow_out=0 throughout.
  - start_valid=1 with a=0x11 during the hold is ignored.
  - Completion occurs on the edge where done_ready=1.
REQ-035 rst_n pulsed low in the 4th RUN cycle -> outputs take the reset values of REQ-028 at once; no done_valid appears afterwards; a fresh request 0x10-0x01 then yields result=0x0F, borrow_out=0.
REQ-036 Randomized check: at least 1000 random (a, b, borrow_in) triples against the reference model {borrow_out, result} = (a - b - borrow_in) mod 2^9, with borrow_out being bit 8.
